// File: rtl/memory_responder_pkg.sv
// Shared types and constants for the memory responder and its boot loader.
package memory_responder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    RUN,
    ERROR
  } state_t;

  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

  // Boot header: payload length occupies ADDR_WIDTH+1 bits starting here.
  localparam int unsigned HDR_LEN_LSB = 0;

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_WIDTH word array: combinational read, synchronous write.
module mem_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (write_enable) mem[write_address] <= write_data;
  end

  assign read_data = mem[read_address];

endmodule

// File: rtl/memory_responder.sv
// Instruction/data memory responder with a streaming, checksummed boot loader
// that holds the core in reset until a verified image is resident.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(DEFAULT_NOP_WORD)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] instruction_address,
  output logic [DATA_WIDTH-1:0] instruction_data,
  input  logic [ADDR_WIDTH-1:0] data_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  input  logic                  boot_valid,
  input  logic [DATA_WIDTH-1:0] boot_data,
  output logic                  boot_ready,
  input  logic                  boot_start,
  output logic                  cpu_reset,
  output logic                  boot_done,
  output logic                  boot_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int unsigned         DEPTH       = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_COUNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE         = (ADDR_WIDTH+1)'(1);

  state_t                state;
  logic [ADDR_WIDTH:0]   length;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   next_count;
  logic [DATA_WIDTH-1:0] checksum;
  logic [ADDR_WIDTH:0]   header_len;
  logic                  transfer;
  logic                  imem_write;
  logic                  dmem_write;
  logic [DATA_WIDTH-1:0] imem_rdata;

  assign transfer     = boot_valid && boot_ready;
  assign header_len   = boot_data[HDR_LEN_LSB +: ADDR_WIDTH+1];
  assign next_count   = count + ONE;
  assign imem_write   = transfer && (state == LOAD);
  assign dmem_write   = write_enable && (state == RUN);
  assign words_loaded = count;
  assign instruction_data = (state == RUN) ? imem_rdata : NOP_WORD;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cpu_reset  <= 1'b1;
      boot_done  <= 1'b0;
      boot_error <= 1'b0;
      boot_ready <= 1'b1;
      count      <= '0;
      length     <= '0;
      checksum   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            if (header_len != '0 && header_len <= DEPTH_COUNT) begin
              length   <= header_len;
              count    <= '0;
              checksum <= '0;
              state    <= LOAD;
            end else begin
              state      <= ERROR;
              boot_error <= 1'b1;
              boot_ready <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (transfer) begin
            checksum <= checksum ^ boot_data;
            count    <= next_count;
            if (next_count == length) state <= CHECK;
          end
        end
        CHECK: begin
          if (transfer) begin
            boot_ready <= 1'b0;
            if (boot_data == checksum) begin
              state     <= RUN;
              boot_done <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state      <= ERROR;
              boot_error <= 1'b1;
            end
          end
        end
        RUN: begin
          if (boot_start) begin
            state      <= IDLE;
            cpu_reset  <= 1'b1;
            boot_done  <= 1'b0;
            boot_ready <= 1'b1;
            count      <= '0;
            length     <= '0;
            checksum   <= '0;
          end
        end
        ERROR: begin
          if (boot_start) begin
            state      <= IDLE;
            boot_error <= 1'b0;
            boot_ready <= 1'b1;
            count      <= '0;
            length     <= '0;
            checksum   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) imem (
    .clk          (clk),
    .write_enable (imem_write),
    .write_address(count[ADDR_WIDTH-1:0]),
    .write_data   (boot_data),
    .read_address (instruction_address),
    .read_data    (imem_rdata)
  );

  mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dmem (
    .clk          (clk),
    .write_enable (dmem_write),
    .write_address(data_address),
    .write_data   (write_data),
    .read_address (data_address),
    .read_data    (read_data)
  );

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Responder end of the CPU core's instruction-fetch and data-memory interface: word-addressed instruction memory plus data memory.
- Includes a streaming boot loader. It fills instruction memory from an external word stream, checks a checksum, and then releases the core from reset.
- Sits beside the CPU top level in the SoC wrapper.
- Reads are combinational so the single-cycle core latches results at its own clock edge. Writes are synchronous.

Parameters:
- DATA_WIDTH, 32, word width of both memories and the boot stream.
- ADDR_WIDTH, 8, word-address width; each memory holds DEPTH = 2**ADDR_WIDTH words.
- NOP_WORD, 32'h0000_0000, instruction returned while not in RUN.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- instruction_address  input  ADDR_WIDTH  fetch word address from core
- instruction_data  output  DATA_WIDTH  fetched instruction
- data_address  input  ADDR_WIDTH  data word address from core
- write_data  input  DATA_WIDTH  store data from core
- write_enable  input  1  store strobe from core
- read_data  output  DATA_WIDTH  load data to core
- boot_valid  input  1  boot stream word valid
- boot_data  input  DATA_WIDTH  boot stream word
- boot_ready  output  1  responder accepts boot word
- boot_start  input  1  request reload (honoured in RUN/ERROR only)
- cpu_reset  output  1  holds core in reset; drive to core's reset
- boot_done  output  1  image loaded and verified
- boot_error  output  1  bad header or checksum mismatch
- words_loaded  output  ADDR_WIDTH+1  count of payload words written this boot

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high, sampled on the rising edge.
- Reset values:
  - state=IDLE, cpu_reset=1, boot_done=0, boot_error=0.
  - words_loaded=0, length register=0, checksum accumulator=0.
  - Memory contents are not cleared by reset.
- Handshake: a boot word transfers on a rising edge with boot_valid&&boot_ready. boot_ready=1 in IDLE, LOAD and CHECK, and 0 in RUN and ERROR. boot_data is ignored without a transfer.
- IDLE, header word:
  - N = boot_data[ADDR_WIDTH:0].
  - If 1 <= N <= DEPTH: latch N, clear accumulator and words_loaded, go to LOAD.
  - Otherwise go to ERROR.
- LOAD:
  - Each transfer writes imem[words_loaded] = boot_data, XORs boot_data into the accumulator, and increments words_loaded.
  - On the transfer that makes words_loaded==N, go to CHECK.
- CHECK, checksum transfer:
  - If boot_data == accumulator: go to RUN, with boot_done=1 and cpu_reset=0 from the next cycle.
  - Else go to ERROR, with boot_error=1 and cpu_reset held at 1.
- RUN:
  - cpu_reset=0, boot_done=1.
  - boot_start=1 → IDLE, cpu_reset=1, boot_done=0, counters cleared.
- ERROR:
  - cpu_reset=1, boot_error=1.
  - boot_start=1 → IDLE, boot_error=0, counters cleared.
- boot_start is ignored in IDLE, LOAD and CHECK.
- Fetch port: instruction_data = imem[instruction_address] combinationally in RUN; NOP_WORD in all other states.
- Data port:
  - read_data = dmem[data_address] combinationally, in all states.
  - Writes happen on the rising edge when write_enable && state==RUN; write_enable is ignored outside RUN.
  - Read-during-write to the same address returns the old word in that cycle and the new word afterwards.
- Width rules:
  - Addresses are word addresses and are used directly, with no wrap logic needed since they are ADDR_WIDTH wide.
  - Header bits above ADDR_WIDTH are ignored.
  - words_loaded is ADDR_WIDTH+1 bits so it can reach DEPTH.
- Reset during LOAD or CHECK: return to IDLE. Partially written imem words are retained but are unreachable until a verified boot.
- Simultaneous reset and boot_start: reset wins.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LOAD, CHECK, RUN, ERROR);
  - NOP_WORD;
  - the header length field position.
- One natural sub-module, mem_array: a parameterised DEPTH x DATA_WIDTH array with combinational read and synchronous write-enable. It is instantiated twice, as imem and dmem. The loader FSM stays in memory_responder.

Test Plan:
- Reset, then stream header 3 and words 0x11, 0x22, 0x44, then checksum 0x77 → boot_done=1, cpu_reset=0 one cycle after the checksum edge, words_loaded=3; fetches at addresses 0,1,2 return 0x11, 0x22, 0x44.
- Same stream with checksum 0x76 → boot_error=1, cpu_reset=1, boot_ready=0, instruction_data=NOP_WORD. Then pulse boot_start → IDLE with boot_error=0, and a valid reload succeeds.
- Header 0, and separately header 257 with ADDR_WIDTH=8 → ERROR on the header edge, with no imem write.
- In RUN: write_enable=1, data_address=0x10, write_data=0xDEADBEEF → read_data at 0x10 is the old value in the same cycle and 0xDEADBEEF in the next. With write_enable asserted before boot_done, dmem is unchanged.
- boot_valid toggling every other cycle during LOAD → only handshaken words are counted and checksummed, and the final state is correct.
- reset asserted mid-LOAD after 2 of 4 words → state IDLE, words_loaded=0, cpu_reset=1. A fresh full load then succeeds.
